// File: rtl/pipelined_instr_decoder_if.sv
// Fetch/execute-facing handshake and decoded-bundle signals of the decode stage.
interface pipelined_instr_decoder_if #(
  parameter int unsigned XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_imm_src;
  logic [2:0]      out_branch_sel;
  logic            out_load_or_store;
  logic            out_oldpc_control;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic            out_illegal;
  logic            stall;

  modport master (
    output flush, in_valid, instr, pc, out_ready,
    input  in_ready, out_valid, out_pc, out_imm, out_imm_src, out_branch_sel,
           out_load_or_store, out_oldpc_control, out_rd, out_rs1, out_rs2,
           out_illegal, stall
  );

  modport slave (
    input  flush, in_valid, instr, pc, out_ready,
    output in_ready, out_valid, out_pc, out_imm, out_imm_src, out_branch_sel,
           out_load_or_store, out_oldpc_control, out_rd, out_rs1, out_rs2,
           out_illegal, stall
  );
endinterface

// File: rtl/pipelined_instr_decoder.sv
// RV32I/RV64I decode stage: one-entry registered output, flush, illegal flagging
// and a single-bubble load-use interlock.
module pipelined_instr_decoder #(
  parameter int unsigned XLEN           = 32,
  parameter bit          LOAD_USE_CHECK = 1'b1
) (
  input logic                clk,
  input logic                reset,
  pipelined_instr_decoder_if.slave bus
);
  localparam int unsigned SHW = (XLEN == 64) ? 6 : 5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [2:0] IMM_I  = 3'b000;
  localparam logic [2:0] IMM_B  = 3'b001;
  localparam logic [2:0] IMM_S  = 3'b010;
  localparam logic [2:0] IMM_SH = 3'b011;
  localparam logic [2:0] IMM_U  = 3'b100;
  localparam logic [2:0] IMM_J  = 3'b101;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  logic [2:0]      d_imm_src, d_branch_sel;
  logic            d_ls, d_oldpc, d_ill;
  logic [XLEN-1:0] d_imm;
  logic            use_rd, use_rs1, use_rs2;
  logic [4:0]      d_rd, d_rs1, d_rs2;
  logic            shadow_valid;
  logic [4:0]      shadow_rd;
  logic            stall_c, ready_c, fire_c, consume_c, out_is_load_c;

  assign opcode = bus.instr[6:0];
  assign funct3 = bus.instr[14:12];

  assign imm_i  = XLEN'($signed(bus.instr[31:20]));
  assign imm_s  = XLEN'($signed({bus.instr[31:25], bus.instr[11:7]}));
  assign imm_b  = XLEN'($signed({bus.instr[31], bus.instr[7], bus.instr[30:25],
                                 bus.instr[11:8], 1'b0}));
  assign imm_u  = XLEN'($signed({bus.instr[31:12], 12'h000}));
  assign imm_j  = XLEN'($signed({bus.instr[31], bus.instr[19:12], bus.instr[20],
                                 bus.instr[30:21], 1'b0}));
  assign imm_sh = XLEN'(bus.instr[19+SHW:20]);

  // Combinational decode of the presented instruction.
  always_comb begin
    d_imm_src    = IMM_I;
    d_branch_sel = 3'b000;
    d_ls         = 1'b0;
    d_oldpc      = 1'b0;
    d_ill        = 1'b0;
    d_imm        = '0;
    use_rd       = 1'b0;
    use_rs1      = 1'b0;
    use_rs2      = 1'b0;
    case (opcode)
      OP_LOAD: begin
        d_ls = 1'b1; d_imm = imm_i; use_rd = 1'b1; use_rs1 = 1'b1;
      end
      OP_IMM: begin
        use_rd = 1'b1; use_rs1 = 1'b1;
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          d_imm_src = IMM_SH; d_imm = imm_sh;
        end else begin
          d_imm = imm_i;
        end
      end
      OP_JALR: begin
        d_oldpc = 1'b1; d_imm = imm_i; use_rd = 1'b1; use_rs1 = 1'b1;
      end
      OP_JAL: begin
        d_imm_src = IMM_J; d_imm = imm_j; use_rd = 1'b1;
      end
      OP_BRANCH: begin
        case (funct3)
          3'b000:  d_branch_sel = 3'b000;
          3'b001:  d_branch_sel = 3'b001;
          3'b100:  d_branch_sel = 3'b010;
          3'b101:  d_branch_sel = 3'b011;
          3'b110:  d_branch_sel = 3'b100;
          3'b111:  d_branch_sel = 3'b101;
          default: d_ill = 1'b1;
        endcase
        if (!d_ill) begin
          d_imm_src = IMM_B; d_imm = imm_b; use_rs1 = 1'b1; use_rs2 = 1'b1;
        end
      end
      OP_STORE: begin
        d_imm_src = IMM_S; d_ls = 1'b1; d_imm = imm_s; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        d_imm_src = IMM_U; d_imm = imm_u; use_rd = 1'b1;
      end
      OP_OP: begin
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      default: d_ill = 1'b1;
    endcase
    d_rd  = use_rd  ? bus.instr[11:7]  : 5'd0;
    d_rs1 = use_rs1 ? bus.instr[19:15] : 5'd0;
    d_rs2 = use_rs2 ? bus.instr[24:20] : 5'd0;
  end

  // Unused source fields read as 0 and shadow_rd is never 0, so they cannot match.
  assign stall_c = LOAD_USE_CHECK && shadow_valid && bus.in_valid && !bus.flush &&
                   ((d_rs1 == shadow_rd) || (d_rs2 == shadow_rd));
  assign ready_c       = bus.flush || ((!bus.out_valid || bus.out_ready) && !stall_c);
  assign fire_c        = bus.in_valid && ready_c;
  assign consume_c     = bus.out_valid && bus.out_ready;
  assign out_is_load_c = bus.out_load_or_store && (bus.out_imm_src == IMM_I);

  assign bus.in_ready = ready_c;
  assign bus.stall    = stall_c;

  // Output register and one-cycle load shadow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_valid         <= 1'b0;
      bus.out_pc            <= '0;
      bus.out_imm           <= '0;
      bus.out_imm_src       <= 3'b000;
      bus.out_branch_sel    <= 3'b000;
      bus.out_load_or_store <= 1'b0;
      bus.out_oldpc_control <= 1'b0;
      bus.out_rd            <= 5'd0;
      bus.out_rs1           <= 5'd0;
      bus.out_rs2           <= 5'd0;
      bus.out_illegal       <= 1'b0;
      shadow_valid          <= 1'b0;
      shadow_rd             <= 5'd0;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
      shadow_valid  <= 1'b0;
    end else begin
      shadow_valid <= consume_c && out_is_load_c && (bus.out_rd != 5'd0);
      if (consume_c) shadow_rd <= bus.out_rd;
      if (fire_c) begin
        bus.out_valid         <= 1'b1;
        bus.out_pc            <= bus.pc;
        bus.out_imm           <= d_imm;
        bus.out_imm_src       <= d_imm_src;
        bus.out_branch_sel    <= d_branch_sel;
        bus.out_load_or_store <= d_ls;
        bus.out_oldpc_control <= d_oldpc;
        bus.out_rd            <= d_rd;
        bus.out_rs1           <= d_rs1;
        bus.out_rs2           <= d_rs2;
        bus.out_illegal       <= d_ill;
      end else if (consume_c) begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pipelined_instr_decoder.sv
// Bench for pipelined_instr_decoder: XLEN=32 and XLEN=64 instances fed the same
// stream, checked every cycle against a spec-level model plus literal spot checks.
module tb_pipelined_instr_decoder;
  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] instr;
  logic [63:0] pc64;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  pipelined_instr_decoder_if #(.XLEN(32)) ifc32 ();
  pipelined_instr_decoder_if #(.XLEN(64)) ifc64 ();

  assign ifc32.flush = flush;      assign ifc64.flush = flush;
  assign ifc32.in_valid = in_valid; assign ifc64.in_valid = in_valid;
  assign ifc32.instr = instr;      assign ifc64.instr = instr;
  assign ifc32.pc = pc64[31:0];    assign ifc64.pc = pc64;
  assign ifc32.out_ready = out_ready; assign ifc64.out_ready = out_ready;

  pipelined_instr_decoder #(.XLEN(32), .LOAD_USE_CHECK(1'b1)) dut32 (
    .clk(clk), .reset(reset), .bus(ifc32.slave));
  pipelined_instr_decoder #(.XLEN(64), .LOAD_USE_CHECK(1'b1)) dut64 (
    .clk(clk), .reset(reset), .bus(ifc64.slave));

  typedef struct {
    logic [63:0] pc;
    logic [63:0] imm;
    logic [31:0] imm32;
    int src, bsel, rd, rs1, rs2;
    bit ls, oldpc, ill, is_load;
  } mb_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Decode straight from the ISA field rules; integer arithmetic for sign extension.
  function automatic mb_t model_dec(input logic [31:0] i, input logic [63:0] p);
    mb_t b;
    int op, f3;
    bit legal, shamt, br, st, rr;
    longint v;
    b = '{default: 0};
    op = int'(i[6:0]); f3 = int'(i[14:12]);
    legal = 1'b1; shamt = 1'b0; v = 0;
    br = (op == 'h63); st = (op == 'h23); rr = (op == 'h33);
    case (op)
      'h03, 'h67: begin
        v = longint'($signed(i[31:20])); b.ls = (op == 'h03); b.oldpc = (op == 'h67);
      end
      'h13: if (f3 == 1 || f3 == 5) begin
              shamt = 1'b1; b.src = 3; b.imm = 64'(i[25:20]); b.imm32 = 32'(i[24:20]);
            end else v = longint'($signed(i[31:20]));
      'h6F: begin b.src = 5; v = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})); end
      'h63: if (f3 == 2 || f3 == 3) legal = 1'b0;
            else begin
              b.src = 1; b.bsel = (f3 < 4) ? f3 : f3 - 2;
              v = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            end
      'h23: begin b.src = 2; b.ls = 1'b1; v = longint'($signed({i[31:25], i[11:7]})); end
      'h37, 'h17: begin b.src = 4; v = longint'($signed({i[31:12], 12'h000})); end
      'h33: v = 0;
      default: legal = 1'b0;
    endcase
    if (!shamt) begin b.imm = 64'(v); b.imm32 = b.imm[31:0]; end
    if (!legal) begin
      b = '{default: 0};
      b.ill = 1'b1;
    end else begin
      b.is_load = (op == 'h03);
      b.rs1 = (op == 'h37 || op == 'h17 || op == 'h6F) ? 0 : int'(i[19:15]);
      b.rs2 = (br || st || rr) ? int'(i[24:20]) : 0;
      b.rd  = (br || st) ? 0 : int'(i[11:7]);
    end
    b.pc = p;
    return b;
  endfunction

  // Cycle-level model of the handshake; compares on the falling edge, advances on rising.
  bit  m_v = 0, m_sv = 0, n_v = 0, n_sv = 0, e_stall, e_rdy, cons;
  int  m_srd = 0, n_srd = 0;
  mb_t m_b, n_b, cd;

  initial begin
    m_b = '{default: 0};
    forever begin
      @(negedge clk);
      if (reset) begin
        n_v = 0; n_sv = 0; n_srd = 0; n_b = m_b;
      end else begin
        cd = model_dec(instr, pc64);
        e_stall = !flush && in_valid && m_sv && (cd.rs1 == m_srd || cd.rs2 == m_srd);
        e_rdy = flush || ((!m_v || out_ready) && !e_stall);
        chk("in_ready32", 64'(ifc32.in_ready), 64'(e_rdy));
        chk("in_ready64", 64'(ifc64.in_ready), 64'(e_rdy));
        chk("stall32", 64'(ifc32.stall), 64'(e_stall));
        chk("stall64", 64'(ifc64.stall), 64'(e_stall));
        chk("out_valid32", 64'(ifc32.out_valid), 64'(m_v));
        chk("out_valid64", 64'(ifc64.out_valid), 64'(m_v));
        if (m_v) begin
          chk("out_pc32", 64'(ifc32.out_pc), 64'(m_b.pc[31:0]));
          chk("out_pc64", ifc64.out_pc, m_b.pc);
          chk("out_imm32", 64'(ifc32.out_imm), 64'(m_b.imm32));
          chk("out_imm64", ifc64.out_imm, m_b.imm);
          chk("imm_src32", 64'(ifc32.out_imm_src), 64'(m_b.src));
          chk("imm_src64", 64'(ifc64.out_imm_src), 64'(m_b.src));
          chk("branch_sel32", 64'(ifc32.out_branch_sel), 64'(m_b.bsel));
          chk("branch_sel64", 64'(ifc64.out_branch_sel), 64'(m_b.bsel));
          chk("ls32", 64'(ifc32.out_load_or_store), 64'(m_b.ls));
          chk("ls64", 64'(ifc64.out_load_or_store), 64'(m_b.ls));
          chk("oldpc32", 64'(ifc32.out_oldpc_control), 64'(m_b.oldpc));
          chk("oldpc64", 64'(ifc64.out_oldpc_control), 64'(m_b.oldpc));
          chk("illegal32", 64'(ifc32.out_illegal), 64'(m_b.ill));
          chk("illegal64", 64'(ifc64.out_illegal), 64'(m_b.ill));
          chk("rd32", 64'(ifc32.out_rd), 64'(m_b.rd));
          chk("rd64", 64'(ifc64.out_rd), 64'(m_b.rd));
          chk("rs1_32", 64'(ifc32.out_rs1), 64'(m_b.rs1));
          chk("rs1_64", 64'(ifc64.out_rs1), 64'(m_b.rs1));
          chk("rs2_32", 64'(ifc32.out_rs2), 64'(m_b.rs2));
          chk("rs2_64", 64'(ifc64.out_rs2), 64'(m_b.rs2));
        end
        n_b = m_b; n_srd = m_srd;
        if (flush) begin
          n_v = 0; n_sv = 0;
        end else begin
          cons = m_v && out_ready;
          n_sv = cons && m_b.is_load && (m_b.rd != 0);
          if (n_sv) n_srd = m_b.rd;
          if (in_valid && e_rdy) begin n_v = 1; n_b = cd; end
          else if (cons) n_v = 0;
          else n_v = m_v;
        end
      end
      @(posedge clk or posedge reset);
      if (reset) begin m_v = 0; m_sv = 0; m_srd = 0; end
      else begin m_v = n_v; m_sv = n_sv; m_srd = n_srd; m_b = n_b; end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [31:0] i);
    in_valid = 1'b1; instr = i; pc64 = pc64 + 64'd4;
  endtask

  // Present one instruction and wait (bounded) for acceptance.
  task automatic send(input logic [31:0] i);
    bit ok;
    ok = 1'b0;
    drive(i);
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (ifc32.in_ready) ok = 1'b1;
      step();
      if (!ok) out_ready = 1'b1;
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: instr 0x%08h not accepted within 20 cycles", i);
    end
    in_valid = 1'b0;
  endtask

  logic [31:0] tbl [12] = '{32'h00512423, 32'h000280E7, 32'h12345197, 32'h0020F863,
                            32'hFE20C8E3, 32'h402083B3, 32'h0000A283, 32'h00528333,
                            32'h0000A003, 32'h00000333, 32'h00F0E093, 32'h0000300B};

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = 32'h0; pc64 = 64'h0000_0001_0000_1000;
    repeat (2) step();
    @(negedge clk);
    chk("rst_out_valid32", 64'(ifc32.out_valid), 64'd0);
    chk("rst_out_valid64", 64'(ifc64.out_valid), 64'd0);
    chk("rst_stall", 64'(ifc32.stall), 64'd0);
    chk("rst_out_imm64", ifc64.out_imm, 64'd0);
    chk("rst_out_pc64", ifc64.out_pc, 64'd0);
    chk("rst_out_rd32", 64'(ifc32.out_rd), 64'd0);
    step(); reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(ifc32.in_ready), 64'd1);
    step();

    // Back-to-back addi, one per cycle.
    out_ready = 1'b1;
    drive(32'h00500093); step();
    drive(32'hFFF00113);
    @(negedge clk);
    chk("addi1_valid", 64'(ifc32.out_valid), 64'd1);
    chk("addi1_imm", 64'(ifc32.out_imm), 64'd5);
    chk("addi1_rd", 64'(ifc32.out_rd), 64'd1);
    chk("addi1_src", 64'(ifc32.out_imm_src), 64'd0);
    step(); in_valid = 1'b0;
    @(negedge clk);
    chk("addi2_imm32", 64'(ifc32.out_imm), 64'h0000_0000_FFFF_FFFF);
    chk("addi2_imm64", ifc64.out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi2_rd", 64'(ifc32.out_rd), 64'd2);
    step();

    // Backpressure on a BNE.
    out_ready = 1'b0;
    drive(32'hFE209EE3); step();
    drive(32'h00500093);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(ifc32.in_ready), 64'd0);
      chk("bp_branch_sel", 64'(ifc32.out_branch_sel), 64'd1);
      chk("bp_imm_src", 64'(ifc32.out_imm_src), 64'd1);
      chk("bp_imm32", 64'(ifc32.out_imm), 64'h0000_0000_FFFF_FFFC);
      chk("bp_imm64", ifc64.out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
      step();
    end
    out_ready = 1'b1; step(); in_valid = 1'b0; step(); step();

    // Load-use bubble.
    drive(32'h0000A283); step();
    in_valid = 1'b0; step();
    drive(32'h00528333);
    @(negedge clk);
    chk("lu_stall32", 64'(ifc32.stall), 64'd1);
    chk("lu_stall64", 64'(ifc64.stall), 64'd1);
    chk("lu_in_ready", 64'(ifc32.in_ready), 64'd0);
    step();
    @(negedge clk);
    chk("lu_release_stall", 64'(ifc32.stall), 64'd0);
    chk("lu_release_ready", 64'(ifc32.in_ready), 64'd1);
    step(); in_valid = 1'b0;
    @(negedge clk);
    chk("lu_add_rd", 64'(ifc32.out_rd), 64'd6);
    chk("lu_add_rs1", 64'(ifc32.out_rs1), 64'd5);
    step();

    // Flush while a load is held and a jal is presented.
    out_ready = 1'b0;
    drive(32'h0000A283); step();
    drive(32'h008000EF); out_ready = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("fl_in_ready", 64'(ifc32.in_ready), 64'd1);
    chk("fl_stall", 64'(ifc32.stall), 64'd0);
    step(); flush = 1'b0;
    drive(32'h00528333);
    @(negedge clk);
    chk("fl_out_valid", 64'(ifc32.out_valid), 64'd0);
    chk("fl_no_shadow_stall", 64'(ifc32.stall), 64'd0);
    step(); in_valid = 1'b0;
    @(negedge clk);
    chk("fl_add_rd", 64'(ifc32.out_rd), 64'd6);
    step();

    // Illegal opcode, illegal branch, SHAMT, LUI, wide shamt.
    drive(32'h0000007F); step();
    drive(32'h00002063);
    @(negedge clk);
    chk("ill_op", 64'(ifc32.out_illegal), 64'd1);
    chk("ill_op_ls", 64'(ifc32.out_load_or_store), 64'd0);
    chk("ill_op_oldpc", 64'(ifc32.out_oldpc_control), 64'd0);
    step(); drive(32'h4030D093);
    @(negedge clk);
    chk("ill_br", 64'(ifc32.out_illegal), 64'd1);
    chk("ill_br_sel", 64'(ifc32.out_branch_sel), 64'd0);
    step(); drive(32'h80000537);
    @(negedge clk);
    chk("srai_src", 64'(ifc32.out_imm_src), 64'd3);
    chk("srai_imm32", 64'(ifc32.out_imm), 64'd3);
    chk("srai_imm64", ifc64.out_imm, 64'd3);
    step(); drive(32'h02109093);
    @(negedge clk);
    chk("lui_imm64", ifc64.out_imm, 64'hFFFF_FFFF_8000_0000);
    chk("lui_imm32", 64'(ifc32.out_imm), 64'h0000_0000_8000_0000);
    chk("lui_rd", 64'(ifc64.out_rd), 64'd10);
    step(); in_valid = 1'b0;
    @(negedge clk);
    chk("slli_imm64", ifc64.out_imm, 64'd33);
    chk("slli_imm32", 64'(ifc32.out_imm), 64'd1);
    step();

    // Directed sweep with varying backpressure.
    for (int k = 0; k < 12; k++) begin
      out_ready = (k % 3) != 2;
      send(tbl[k]);
    end
    out_ready = 1'b1; step(); step();

    // Reset in the middle of a held bundle.
    out_ready = 1'b0;
    drive(32'h008000EF); step(); in_valid = 1'b0;
    @(negedge clk);
    chk("mr_held", 64'(ifc32.out_valid), 64'd1);
    step(); reset = 1'b1;
    @(negedge clk);
    chk("mr_valid32", 64'(ifc32.out_valid), 64'd0);
    chk("mr_valid64", 64'(ifc64.out_valid), 64'd0);
    step(); reset = 1'b0; step();
    @(negedge clk);
    chk("mr_after_valid", 64'(ifc32.out_valid), 64'd0);
    chk("mr_after_ready", 64'(ifc32.in_ready), 64'd1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
